// File: rtl/difftest_pkg.sv
// Shared trace record layout and default widths for the difftest trace arbiter.
package difftest_pkg;

    localparam int unsigned ARCH_LEN_DEF     = 32;
    localparam int unsigned NUM_LANES_DEF    = 16;
    localparam int unsigned NUM_WARPS_DEF    = 8;
    localparam int unsigned REG_BITS_DEF     = 8;
    localparam int unsigned WARP_ID_BITS_DEF = $clog2(NUM_WARPS_DEF);

    function automatic int unsigned rec_bits(input int unsigned arch_len,
                                             input int unsigned num_lanes,
                                             input int unsigned warp_id_bits,
                                             input int unsigned reg_bits);
        return arch_len + warp_id_bits + 3 * (1 + reg_bits + num_lanes * arch_len);
    endfunction

    localparam int unsigned REC_BITS =
        rec_bits(ARCH_LEN_DEF, NUM_LANES_DEF, WARP_ID_BITS_DEF, REG_BITS_DEF);

    typedef struct packed {
        logic                                    en;
        logic [REG_BITS_DEF-1:0]                 addr;
        logic [NUM_LANES_DEF*ARCH_LEN_DEF-1:0]   data;
    } reg_write_t;

    typedef struct packed {
        logic [ARCH_LEN_DEF-1:0]     pc;
        logic [WARP_ID_BITS_DEF-1:0] warp_id;
        reg_write_t                  wr0;
        reg_write_t                  wr1;
        reg_write_t                  wr2;
    } trace_rec_t;

endpackage

// File: rtl/difftest_trace_fifo.sv
// Per-source record FIFO; head is read straight from the storage registers.
module difftest_trace_fifo
    import difftest_pkg::*;
#(
    parameter int unsigned Width = REC_BITS,
    parameter int unsigned Depth = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [Width-1:0] head_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PtrW:0]      wr_q, wr_d;
    logic [PtrW:0]      rd_q, rd_d;
    logic [Width-1:0]   mem_q [Depth];
    logic               push_ok;
    logic               pop_ok;

    always_comb begin
        full_o  = (wr_q[PtrW] != rd_q[PtrW]) && (wr_q[PtrW-1:0] == rd_q[PtrW-1:0]);
        empty_o = (wr_q == rd_q);
        push_ok = push_i && !full_o;
        pop_ok  = pop_i && !empty_o;
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
        head_o  = mem_q[rd_q[PtrW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage needs no reset: stale entries are never visible while empty.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_q[PtrW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/difftest_trace_arbiter.sv
// Round-robin merge of per-source trace FIFOs onto the single difftest trace port.
module difftest_trace_arbiter
    import difftest_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ARCH_LEN   = ARCH_LEN_DEF,
    parameter int unsigned NUM_LANES  = NUM_LANES_DEF,
    parameter int unsigned NUM_WARPS  = NUM_WARPS_DEF,
    parameter int unsigned REG_BITS   = REG_BITS_DEF,
    localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS),
    localparam int unsigned RecBits  = rec_bits(ARCH_LEN, NUM_LANES, WARP_ID_BITS, REG_BITS),
    localparam int unsigned SrcBits  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         in_valid,
    output logic [NUM_SRC-1:0]         in_ready,
    input  logic [NUM_SRC*RecBits-1:0] in_rec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [RecBits-1:0]         out_rec,
    output logic [SrcBits-1:0]         out_src,
    output logic                       idle,
    output logic [31:0]                retired
);

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [RecBits-1:0] head [NUM_SRC];

    logic [SrcBits-1:0] rr_ptr_q, rr_ptr_d;
    logic               lock_q, lock_d;
    logic [SrcBits-1:0] lock_src_q, lock_src_d;
    logic [31:0]        retired_q, retired_d;

    logic [SrcBits-1:0] search_src;
    logic               found;
    logic [SrcBits-1:0] grant;
    logic               handshake;
    int unsigned        idx;

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        assign push[s] = in_valid[s] && !full[s];
        assign pop[s]  = handshake && (grant == SrcBits'(s));

        difftest_trace_fifo #(
            .Width (RecBits),
            .Depth (FIFO_DEPTH)
        ) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .push_i  (push[s]),
            .data_i  (in_rec[s*RecBits +: RecBits]),
            .pop_i   (pop[s]),
            .full_o  (full[s]),
            .empty_o (empty[s]),
            .head_o  (head[s])
        );
    end

    // First non-empty FIFO at or after rr_ptr, wrapping.
    always_comb begin
        found      = 1'b0;
        search_src = '0;
        idx        = 0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (32'(rr_ptr_q) + 32'(i)) % NUM_SRC;
            if (!found && !empty[idx]) begin
                found      = 1'b1;
                search_src = SrcBits'(idx);
            end
        end
    end

    // A stalled grant is pinned so a newly filled FIFO cannot steal it.
    always_comb begin
        grant     = lock_q ? lock_src_q : search_src;
        out_valid = !(&empty);
        handshake = out_valid && out_ready;
        out_src   = out_valid ? grant : '0;
        out_rec   = out_valid ? head[grant] : '0;
        in_ready  = ~full;
        idle      = (&empty) && !(|in_valid);
        retired   = retired_q;
    end

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        retired_d  = retired_q;
        lock_d     = out_valid && !out_ready;
        lock_src_d = grant;
        if (handshake) begin
            rr_ptr_d = (grant == SrcBits'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
            if (retired_q != 32'hFFFF_FFFF) begin
                retired_d = retired_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            lock_q     <= 1'b0;
            lock_src_q <= '0;
            retired_q  <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            lock_q     <= lock_d;
            lock_src_q <= lock_src_d;
            retired_q  <= retired_d;
        end
    end

endmodule

// File: doc/difftest_trace_arbiter.md
# difftest_trace_arbiter

Shares the single register-trace difftest port among `NUM_SRC` independent commit streams, e.g. one per core or per writeback cluster. Each source pushes complete trace records (pc, warp, up to three register writes) through a valid/ready handshake into its own small FIFO. A round-robin arbiter drains one record per handshake onto the difftest port. The block sits between the cores' commit/trace outputs and `CyclotronDiffTestBlackBox`. It also reports an idle flag and a retired-record count so the harness knows when all traces have been compared.

## Interface
Parameters:
- `NUM_SRC`, 4: number of trace sources; ≥1.
- `FIFO_DEPTH`, 4: entries per source FIFO; power of two, ≥2.
- `ARCH_LEN`, 32: register data width per lane.
- `NUM_LANES`, 16: lanes per register write.
- `NUM_WARPS`, 8: warps per core; `WARP_ID_BITS = $clog2(NUM_WARPS)`.
- `REG_BITS`, 8: register address width.

Ports (reset reset, synchronous, active-high; clock clock):
- `clock`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  NUM_SRC  per-source record valid.
- `in_ready`  out  NUM_SRC  per-source FIFO not full.
- `in_rec`  in  NUM_SRC×REC_BITS  packed `trace_rec_t` per source, where source *s* occupies slice *s*.
- `out_valid`  out  1  record presented to difftest.
- `out_ready`  in  1  difftest consumes this cycle; tie to 1 when the DPI model ticks internally.
- `out_rec`  out  REC_BITS  granted record; fields map 1:1 to the difftest `trace_*` ports.
- `out_src`  out  $clog2(NUM_SRC)  source index of the granted record.
- `idle`  out  1  all FIFOs empty and no `in_valid` asserted.
- `retired`  out  32  count of `out_valid && out_ready` handshakes; saturates at 2^32−1.

## Operation
- Enqueue: source *s* fires when `in_valid[s] && in_ready[s]`. The record is written to FIFO *s*.
  - `in_ready[s]` = !full[s]. It depends only on FIFO state and never on `out_ready`.
- Arbitration: round-robin over sources with non-empty FIFOs.
  - Search starts at `rr_ptr` and takes the first non-empty FIFO in increasing index order, wrapping modulo `NUM_SRC`.
- `out_valid` = any FIFO non-empty. `out_rec` and `out_src` come from the granted FIFO head.
- The grant is held stable while `out_valid && !out_ready`. `rr_ptr` does not move during backpressure.
- On a handshake: the granted FIFO pops, `retired` increments, and `rr_ptr` ← (grant+1) mod `NUM_SRC`.
- Ordering:
  - Records from one source leave in enqueue order.
  - No ordering is guaranteed across sources. The Cyclotron comparison is per-warp/pc, so cross-source order does not matter.
- Record contents pass through unmodified. Register-enable bits are not inspected.

## Timing
- Reset values: `in_ready` all 1, `out_valid` 0, `out_src` 0, `out_rec` 0, `idle` 1, `retired` 0, `rr_ptr` 0, all FIFOs empty.
- Latency: a record enqueued in cycle *t* can appear on `out_valid` at cycle *t*+1 at the earliest. There is no combinational in→out path.
- `out_valid`/`out_src`/`out_rec` are combinational from FIFO head registers and `rr_ptr`. They do not depend on `out_ready`.
- Full FIFO with a simultaneous pop: `in_ready` is still 0 that cycle. The freed slot is visible next cycle.
- Empty FIFO with simultaneous push and grant elsewhere: the push lands and becomes eligible next cycle.
- Single active source: that source gets one record per cycle, so throughput is 1/cycle.
- All sources continuously full: each source gets exactly one grant per `NUM_SRC` handshakes.
- Reset mid-operation: all FIFO contents are discarded, pointers and counters clear, and outputs return to their reset values in the following cycle.
- `idle` is combinational. It may drop in the same cycle `in_valid` rises.

## Structure
- Package `difftest_pkg`:
  - `trace_rec_t` packed struct, in field order: valid-independent `pc[ARCH_LEN]`, `warp_id[WARP_ID_BITS]`, then 3 × {`en`, `addr[REG_BITS]`, `data[NUM_LANES*ARCH_LEN]`}.
  - `REC_BITS` localparam function.
  - Default widths.
- Sub-module `difftest_trace_fifo`: synchronous FIFO of `trace_rec_t`, depth `FIFO_DEPTH`, with push/pop/full/empty and a registered head. The top instantiates it `NUM_SRC` times.
- The top holds the round-robin pointer, priority search, output mux, `retired` counter and `idle` logic.

## Test plan
1. Reset with no stimulus → `out_valid`=0, `idle`=1, `in_ready`=4'b1111, `retired`=0 for 10 cycles.
2. Source 2 pushes pc=0x8000_0000, warp 3, reg0 en addr 5 lanes=i → next cycle `out_valid`=1, `out_src`=2, identical record; after the pop `retired`=1 and `idle`=1.
3. All 4 sources hold 4 records each and `out_ready`=1 → grant order 0,1,2,3 repeated 4 times, 16 handshakes in 16 cycles, per-source order preserved.
4. `out_ready`=0 for 5 cycles with source 1 pending → `out_src`/`out_rec` stable, `rr_ptr` unchanged, `retired` unchanged; source 1 fills to 4 and `in_ready[1]`=0; a 5th push is held and not lost.
5. Full source 0 with `out_ready`=1 and `in_valid[0]`=1 → `in_ready[0]` stays 0 in the pop cycle and rises next cycle; no record is dropped or duplicated (scoreboard).
6. Reset asserted with 3 records queued → the next cycle shows `out_valid`=0, `retired`=0, `rr_ptr`=0; later traffic starts grant search at source 0.
